// File: rtl/md_issue_ctrl.sv
// Issue controller between the pipeline and the multiply/divide unit: accepts one MD-class
// instruction at a time, watches the unit's busy flag, and cancels on flush or watchdog expiry.
module md_issue_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs,
  input  logic [31:0] req_rt,
  output logic        req_ready,
  output logic        stall,
  input  logic        flush,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  output logic [3:0]  md_ctrl,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_goback,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        md_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    CANCEL = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   d1_q, d1_d;
  logic [31:0]   d2_q, d2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          mt_gb_q, mt_gb_d;
  logic          rdv_q, rdv_d;
  logic [31:0]   rdd_q, rdd_d;

  logic          idle_free_s;
  logic          acc_md_s;
  logic          acc_mt_s;
  logic          acc_mf_s;

  // Acceptance decode; reset is folded in so nothing is accepted while it is held low.
  always_comb begin
    idle_free_s = reset && (state_q == IDLE) && !md_busy && req_valid;
    acc_md_s    = idle_free_s && !req_op[2] && !flush;
    acc_mt_s    = idle_free_s && (req_op[2:1] == 2'b10);
    acc_mf_s    = idle_free_s && (req_op[2:1] == 2'b11) && !flush;
  end

  // State, watchdog counter and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= 2'd0;
      d1_q    <= 32'd0;
      d2_q    <= 32'd0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      mt_gb_q <= 1'b0;
      rdv_q   <= 1'b0;
      rdd_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      mt_gb_q <= mt_gb_d;
      rdv_q   <= rdv_d;
      rdd_q   <= rdd_d;
    end
  end

  // Next-state logic; the WAIT dwell check uses cnt_q so at least two WAIT cycles elapse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (acc_md_s) state_d = ISSUE;
        else          state_d = IDLE;
      end
      ISSUE: begin
        cnt_d = '0;
        if (flush) state_d = CANCEL;
        else       state_d = WAIT;
      end
      WAIT: begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
        if (flush) begin
          state_d = CANCEL;
        end else if (!md_busy && (cnt_q != '0)) begin
          state_d = IDLE;
        end else if (cnt_d == CNT_MAX) begin
          state_d = CANCEL;
          err_d   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      CANCEL: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Operand latch, MFHI/MFLO result register, and MT-with-flush rollback request.
  always_comb begin
    mt_gb_d = acc_mt_s && flush;
    rdv_d   = acc_mf_s;
    if (acc_md_s) begin
      op_d = req_op[1:0];
      d1_d = req_rs;
      d2_d = req_rt;
    end else begin
      op_d = op_q;
      d1_d = d1_q;
      d2_d = d2_q;
    end
    if (acc_mf_s) rdd_d = req_op[0] ? md_lo : md_hi;
    else          rdd_d = rdd_q;
  end

  // MD unit command: latched op in ISSUE, MTHI/MTLO passed straight through from IDLE.
  always_comb begin
    md_ctrl = 4'd15;
    md_d1   = d1_q;
    if (state_q == ISSUE) begin
      md_ctrl = {2'b00, op_q};
      md_d1   = d1_q;
    end else if (acc_mt_s) begin
      md_ctrl = {3'b010, req_op[0]};
      md_d1   = req_rs;
    end else begin
      md_ctrl = 4'd15;
      md_d1   = d1_q;
    end
  end

  assign md_d2     = d2_q;
  assign req_ready = acc_md_s | acc_mt_s | acc_mf_s;
  assign stall     = req_valid & ~req_ready;
  assign md_goback = (state_q == CANCEL) | mt_gb_q;
  assign rd_valid  = rdv_q;
  assign rd_data   = rdd_q;
  assign md_err    = err_q;

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed bench for md_issue_ctrl with a behavioural MD unit; MFHI/MFLO results are
// checked through an expected-value queue, everything else with immediate assertions.
module tb_md_issue_ctrl;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_DIV   = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_rs, req_rt;
  logic        req_ready, stall, flush;
  logic [31:0] md_d1, md_d2;
  logic [3:0]  md_ctrl;
  logic        md_busy;
  logic [31:0] md_hi, md_lo;
  logic        md_goback, rd_valid, md_err;
  logic [31:0] rd_data;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  int          lat = 5;
  bit          stuck = 1'b0;
  int          cnt_m;
  logic [31:0] sav_hi, sav_lo, pend_hi, pend_lo;

  md_issue_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_rs(req_rs), .req_rt(req_rt), .req_ready(req_ready), .stall(stall),
    .flush(flush), .md_d1(md_d1), .md_d2(md_d2), .md_ctrl(md_ctrl),
    .md_busy(md_busy), .md_hi(md_hi), .md_lo(md_lo), .md_goback(md_goback),
    .rd_valid(rd_valid), .rd_data(rd_data), .md_err(md_err)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] md_calc(logic [3:0] c, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    case (c)
      4'd0:    return sa * sb;
      4'd1:    return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
      4'd2:    return {32'd0, a} * {32'd0, b};
      default: return {a % b, a / b};
    endcase
  endfunction

  // Behavioural MD unit: busy for lat cycles, HI/LO rollback on goback.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_busy <= 1'b0; cnt_m <= 0;
      md_hi <= 32'd0; md_lo <= 32'd0; sav_hi <= 32'd0; sav_lo <= 32'd0;
      pend_hi <= 32'd0; pend_lo <= 32'd0;
    end else if (md_goback) begin
      md_busy <= 1'b0; cnt_m <= 0; md_hi <= sav_hi; md_lo <= sav_lo;
    end else if (md_ctrl == 4'd4) begin
      sav_hi <= md_hi; sav_lo <= md_lo; md_hi <= md_d1;
    end else if (md_ctrl == 4'd5) begin
      sav_hi <= md_hi; sav_lo <= md_lo; md_lo <= md_d1;
    end else if (md_ctrl <= 4'd3) begin
      md_busy <= 1'b1; cnt_m <= lat;
      {pend_hi, pend_lo} <= md_calc(md_ctrl, md_d1, md_d2);
    end else if (md_busy && !stuck) begin
      if (cnt_m <= 1) begin
        md_busy <= 1'b0; md_hi <= pend_hi; md_lo <= pend_lo;
        sav_hi <= pend_hi; sav_lo <= pend_lo;
      end else begin
        cnt_m <= cnt_m - 1;
      end
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic v, logic [2:0] op, logic [31:0] rs, logic [31:0] rt);
    req_valid = v; req_op = op; req_rs = rs; req_rt = rt;
  endtask

  // Called at +3 in the ISSUE cycle: counts stalled cycles until the pending request is taken.
  task automatic wait_accept(string tag, logic [3:0] issue_ctrl, int exp_stalls);
    int n;
    n = 0;
    while (!req_ready && n < 40) begin
      chk({tag, "_ctrl"}, 32'(md_ctrl), (n == 0) ? 32'(issue_ctrl) : 32'd15);
      n++;
      @(posedge clk); #3;
    end
    chk({tag, "_stall_cycles"}, 32'(n), 32'(exp_stalls));
  endtask

  // Scoreboard: every rd_valid pulse consumes one expected MFHI/MFLO result.
  always @(negedge clk) begin
    if (reset === 1'b1 && rd_valid === 1'b1) begin
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL rd_unexpected: observed %0h expected no result", rd_data);
      end
      if (exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
        vectors++;
        assert (rd_data === exp_v) else begin
          miscompares++;
          $error("FAIL rd_data: observed %0h expected %0h", rd_data, exp_v);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    reset = 1'b0; flush = 1'b0;
    drive(1'b0, OP_MULT, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #3;
    chk("rst_ctrl", 32'(md_ctrl), 32'd15);
    chk("rst_d1", md_d1, 32'd0);
    chk("rst_d2", md_d2, 32'd0);
    chk("rst_goback", 32'(md_goback), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_err", 32'(md_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b1;

    // MULT -2*3, then MFLO/MFHI
    drive(1'b1, OP_MULT, 32'hFFFFFFFE, 32'd3); #2;
    chk("t1_ready", 32'(req_ready), 32'd1);
    chk("t1_stall", 32'(stall), 32'd0);
    chk("t1_idle_ctrl", 32'(md_ctrl), 32'd15);
    tick();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0); exp_q.push_back(32'hFFFFFFFA); #2;
    chk("t1_d1", md_d1, 32'hFFFFFFFE);
    chk("t1_d2", md_d2, 32'd3);
    chk("t1_issue_stall", 32'(stall), 32'd1);
    wait_accept("t1", 4'd0, 7);
    tick();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0); exp_q.push_back(32'hFFFFFFFF); #2;
    chk("t1_mfhi_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0); tick();

    // DIVU 100/7 followed by MFHI
    drive(1'b1, OP_DIVU, 32'd100, 32'd7); #2;
    chk("t2_ready", 32'(req_ready), 32'd1);
    tick();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0); exp_q.push_back(32'd2); #2;
    wait_accept("t2", 4'd3, 7);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0); tick(); tick();

    // MTHI / MTLO then read back
    drive(1'b1, OP_MTHI, 32'h12345678, 32'd0); #2;
    chk("t3_ready", 32'(req_ready), 32'd1);
    chk("t3_stall", 32'(stall), 32'd0);
    chk("t3_ctrl", 32'(md_ctrl), 32'd4);
    chk("t3_d1", md_d1, 32'h12345678);
    tick();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0); exp_q.push_back(32'h12345678); #2;
    chk("t3_mf_ready", 32'(req_ready), 32'd1);
    chk("t3_mf_ctrl", 32'(md_ctrl), 32'd15);
    tick();
    drive(1'b1, OP_MTLO, 32'hA5A5F00F, 32'd0); #2;
    chk("t3_mtlo_ctrl", 32'(md_ctrl), 32'd5);
    tick();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0); exp_q.push_back(32'hA5A5F00F); #2;
    chk("t3_mflo_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0);
    tick(); #2;
    chk("t3_rd_pulse", 32'(rd_valid), 32'd0);

    // DIV flushed on the third WAIT cycle
    lat = 10;
    drive(1'b1, OP_DIV, 32'hFFFFFFEC, 32'd3); #2;
    chk("t4_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0); #2;
    chk("t4_ctrl", 32'(md_ctrl), 32'd1);
    tick(); tick(); tick();
    flush = 1'b1; #2;
    chk("t4_goback_early", 32'(md_goback), 32'd0);
    tick(); flush = 1'b0; #2;
    chk("t4_goback", 32'(md_goback), 32'd1);
    tick(); lat = 5;
    drive(1'b1, OP_MULT, 32'h00012345, 32'h00100000); #2;
    chk("t4_goback_single", 32'(md_goback), 32'd0);
    chk("t4_new_ready", 32'(req_ready), 32'd1);
    tick();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0); exp_q.push_back(32'h34500000); #2;
    wait_accept("t4", 4'd0, 7);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0); tick(); tick();

    // busy stuck high: watchdog
    stuck = 1'b1;
    drive(1'b1, OP_MULT, 32'd7, 32'd9); #2;
    chk("t5_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0);
    tick(); #2;
    n = 0;
    while (!md_goback && n < 40) begin
      if (n == 0) chk("t5_err_clear", 32'(md_err), 32'd0);
      n++;
      tick(); #2;
    end
    chk("t5_wait_cycles", 32'(n), 32'd16);
    chk("t5_err", 32'(md_err), 32'd1);
    tick(); #2;
    stuck = 1'b0;
    chk("t5_goback_end", 32'(md_goback), 32'd0);
    chk("t5_err_sticky", 32'(md_err), 32'd1);

    // flush in IDLE blocks acceptance without goback
    drive(1'b1, OP_MULT, 32'd1, 32'd1); flush = 1'b1; #2;
    chk("t6_ready", 32'(req_ready), 32'd0);
    chk("t6_stall", 32'(stall), 32'd1);
    tick(); flush = 1'b0; drive(1'b0, OP_MULT, 32'd0, 32'd0); #2;
    chk("t6_goback", 32'(md_goback), 32'd0);
    chk("t6_ctrl", 32'(md_ctrl), 32'd15);

    // MTHI with flush: accepted, then rolled back
    drive(1'b1, OP_MTHI, 32'hDEADBEEF, 32'd0); flush = 1'b1; #2;
    chk("t7_ready", 32'(req_ready), 32'd1);
    chk("t7_ctrl", 32'(md_ctrl), 32'd4);
    tick(); flush = 1'b0; drive(1'b0, OP_MULT, 32'd0, 32'd0); #2;
    chk("t7_goback", 32'(md_goback), 32'd1);
    tick(); #2;
    chk("t7_goback_end", 32'(md_goback), 32'd0);
    drive(1'b1, OP_MFHI, 32'd0, 32'd0); exp_q.push_back(32'h00000012);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0); tick();

    // reset in WAIT, then MULTU
    drive(1'b1, OP_MULT, 32'd3, 32'd4); #2;
    chk("t8_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0);
    tick();
    reset = 1'b0; #1;
    chk("t8_rst_ctrl", 32'(md_ctrl), 32'd15);
    chk("t8_rst_d1", md_d1, 32'd0);
    chk("t8_rst_d2", md_d2, 32'd0);
    chk("t8_rst_goback", 32'(md_goback), 32'd0);
    chk("t8_rst_rd_data", rd_data, 32'd0);
    chk("t8_rst_err", 32'(md_err), 32'd0);
    tick(); tick();
    reset = 1'b1;
    drive(1'b1, OP_MULTU, 32'hFFFFFFFF, 32'd2); #2;
    chk("t8_post_ready", 32'(req_ready), 32'd1);
    chk("t8_post_goback", 32'(md_goback), 32'd0);
    tick();
    drive(1'b1, OP_MFLO, 32'd0, 32'd0); exp_q.push_back(32'hFFFFFFFE); #2;
    wait_accept("t8", 4'd2, 7);
    tick();
    drive(1'b1, OP_MFHI, 32'd0, 32'd0); exp_q.push_back(32'd1); #2;
    chk("t8_mfhi_ready", 32'(req_ready), 32'd1);
    tick(); drive(1'b0, OP_MULT, 32'd0, 32'd0); tick(); tick();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the maximum number of cycles spent in WAIT before the watchdog fires.
REQ-002 clk  input  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  input  1  asynchronous, active-low; low SHALL force the reset state immediately, independent of clk.
REQ-004 req_valid  input  1  pipeline presents an MD-class instruction this cycle.
REQ-005 req_op  input  3  0 MULT, 1 DIV, 2 MULTU, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-006 req_rs, req_rt  input  32 each  forwarded operand values.
REQ-007 req_ready  output  1  request accepted this cycle.
REQ-008 stall  output  1  freeze pipeline; SHALL equal req_valid & ~req_ready.
REQ-009 flush  input  1  exception/rollback of the in-flight MD operation.
REQ-010 md_d1, md_d2  output  32 each  operands to the multiply/divide unit.
REQ-011 md_ctrl  output  4  op code to the MD unit; 15 = no operation.
REQ-012 md_busy  input  1  MD unit busy flag.
REQ-013 md_hi, md_lo  input  32 each  MD unit HI/LO.
REQ-014 md_goback  output  1  cancel pulse to the MD unit.
REQ-015 rd_valid  output  1, rd_data  output  32  registered MFHI/MFLO result.
REQ-016 md_err  output  1  sticky watchdog error.

Function
REQ-017 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT and CANCEL, with IDLE as the reset state.
REQ-018 In IDLE, req_valid with req_op<=3 and flush=0 SHALL assert req_ready, register req_rs into md_d1 and req_rt into md_d2, and go to ISSUE.
REQ-019 In ISSUE, md_ctrl SHALL equal the latched op for exactly one cycle, then the FSM SHALL go to WAIT; in all other states md_ctrl SHALL be 15 except as given in REQ-021.
REQ-020 In WAIT, the FSM SHALL return to IDLE on the first cycle with md_busy=0 after at least 2 cycles in WAIT; the minimum-dwell rule covers the MD unit's negedge start latency.
REQ-021 In IDLE with md_busy=0, MTHI/MTLO SHALL assert req_ready, drive md_ctrl=4/5 and md_d1=req_rs combinationally that cycle, and remain in IDLE.
REQ-022 MFHI/MFLO SHALL be accepted only in IDLE with md_busy=0; rd_data SHALL be md_hi/md_lo registered, with rd_valid pulsing 1 cycle after acceptance.
REQ-023 Any MD request while the state is not IDLE, or while md_busy=1, SHALL hold req_ready=0 so that stall=1.
REQ-024 flush in ISSUE or WAIT SHALL move the FSM to CANCEL; CANCEL SHALL assert md_goback for exactly 1 cycle, then return to IDLE.
REQ-025 flush in IDLE SHALL block acceptance that cycle and SHALL NOT pulse md_goback.
REQ-026 flush together with MTHI/MTLO acceptance in the same cycle SHALL pulse md_goback the next cycle so that the MD unit restores the old HI/LO.
REQ-027 A WAIT-cycle counter SHALL saturate at TIMEOUT; on reaching it, md_err SHALL set (sticky) and the FSM SHALL go to CANCEL.
REQ-028 Only one MD operation SHALL be outstanding at any time, and no request SHALL be queued.

Reset
REQ-029 Reset SHALL set: state IDLE, md_ctrl=15, md_d1=md_d2=0, md_goback=0, rd_valid=0, rd_data=0, md_err=0, WAIT counter 0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation without a goback pulse; the first cycle after release SHALL be IDLE with req_ready evaluable.

Verification
REQ-031 MULT, rs=0xFFFFFFFE, rt=3, model busy for 5 cycles -> md_ctrl=0 for one cycle, stall held until busy drops, then MFLO -> rd_data=0xFFFFFFFA, MFHI -> 0xFFFFFFFF.
REQ-032 DIVU 100/7 followed immediately by MFHI -> MFHI stalled until md_busy=0, then rd_valid with rd_data=2.
REQ-033 MTHI rs=0x12345678, then MFHI -> md_ctrl=4 for 1 cycle, no stall, rd_data=0x12345678.
REQ-034 DIV issued, flush on the 3rd WAIT cycle -> single md_goback pulse, IDLE next, a new MULT is accepted the following cycle.
REQ-035 md_busy stuck at 1 after issue -> after TIMEOUT=16 WAIT cycles md_err=1, md_goback pulse, return to IDLE.
REQ-036 Reset dropped low in WAIT -> outputs at reset values asynchronously; after release, a MULTU 0xFFFFFFFF*2 completes normally.
